// File: rtl/speed_pulse_gen.sv
// -----------------------------------------------------------------------------
// speed_pulse_gen
//
// Tachometer-pulse transmitter. Produces a square wave whose rising-to-rising
// spacing, in clk cycles, equals the currently active period. A new period is
// commanded through a load/ready handshake. The active period is slewed toward
// the commanded target by at most RAMP_STEP per output period, which emulates
// motor acceleration for the speed-measurement logic downstream.
//
// Parameters
//   CNT_W          width of period registers and the phase counter
//   MIN_PERIOD     smallest legal period; smaller commands are clamped up
//   DEFAULT_PERIOD active period and target after reset
//   RAMP_STEP      max change of the active period per output period
//                  (0 = jump straight to the target)
//
// Ports
//   clk             system clock
//   rst             asynchronous, active-high reset
//   i_en            run enable, level sensitive
//   i_period_in     commanded period in clk cycles
//   i_period_load   load request, accepted only while o_period_ready is high
//   o_period_ready  high when idle or when the active period equals the target
//   o_speed_out     generated pulse train
//   o_rise_strobe   one-cycle pulse in the first high cycle of each period
//   o_cur_period    period currently being generated
//   o_edge_cnt      number of rising edges emitted, wraps 65535 -> 0
// -----------------------------------------------------------------------------
module speed_pulse_gen #(
    parameter int CNT_W          = 26,
    parameter int MIN_PERIOD     = 16,
    parameter int DEFAULT_PERIOD = 100,
    parameter int RAMP_STEP      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_period_in,
    input  logic             i_period_load,
    output logic             o_period_ready,
    output logic             o_speed_out,
    output logic             o_rise_strobe,
    output logic [CNT_W-1:0] o_cur_period,
    output logic [15:0]      o_edge_cnt
);

    // -------------------------------------------------------------------------
    // Constants sized to the datapath so every compare/add is width-matched.
    // -------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] STEP  = CNT_W'(RAMP_STEP);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [CNT_W-1:0]   r_phase;        // cycles already spent in HIGH or LOW
    logic [CNT_W-1:0]   r_cur_period;   // period in force for the current cycle
    logic [CNT_W-1:0]   r_target;       // last accepted (clamped) command
    logic               r_speed_out;
    logic               r_rise_strobe;
    logic [15:0]        r_edge_cnt;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_phase_nxt;
    logic [CNT_W-1:0]   w_high_len;
    logic [CNT_W-1:0]   w_low_len;
    logic [CNT_W-1:0]   w_clamped;
    logic [CNT_W-1:0]   w_ramped;
    logic [CNT_W-1:0]   w_cur_nxt;
    logic [CNT_W-1:0]   w_target_nxt;
    logic               w_ready;
    logic               w_load;
    logic               w_start;        // entering HIGH on this edge
    logic               w_last_low;     // final LOW cycle of a period

    // Odd periods put the extra cycle in LOW.
    assign w_high_len = r_cur_period >> 1;
    assign w_low_len  = r_cur_period - w_high_len;

    assign w_clamped  = (i_period_in < MIN_P) ? MIN_P : i_period_in;

    // Ready drops only while the active period is still slewing toward the
    // target, so a load and a ramp update can never land on the same edge.
    assign w_ready    = (r_state == ST_IDLE) || (r_cur_period == r_target);
    assign w_load     = i_period_load && w_ready;

    // -------------------------------------------------------------------------
    // Ramp: move the active period at most STEP toward the target.
    // The add branch is taken only when cur + STEP < target, so it cannot wrap;
    // that is equivalent to a saturating add followed by min(target). The
    // subtract branch likewise never undershoots the target, so the result
    // never drops below MIN_PERIOD.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_ramped = r_target;
        if (RAMP_STEP != 0) begin
            if (r_cur_period < r_target) begin
                if ((r_target - r_cur_period) > STEP) begin
                    w_ramped = r_cur_period + STEP;
                end
            end else if (r_cur_period > r_target) begin
                if ((r_cur_period - r_target) > STEP) begin
                    w_ramped = r_cur_period - STEP;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_start     = 1'b0;
        w_last_low  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = '0;
                if (i_en) begin
                    w_state_nxt = ST_HIGH;
                    w_start     = 1'b1;
                end
            end

            ST_HIGH: begin
                if (r_phase == w_high_len - ONE) begin
                    w_state_nxt = ST_LOW;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + ONE;
                end
            end

            ST_LOW: begin
                if (r_phase == w_low_len - ONE) begin
                    // A period always completes; en is sampled only here, so
                    // dropping it mid-period never produces a runt pulse.
                    w_last_low  = 1'b1;
                    w_phase_nxt = '0;
                    if (i_en) begin
                        w_state_nxt = ST_HIGH;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_phase_nxt = r_phase + ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Period / target next values
    // -------------------------------------------------------------------------
    always_comb begin
        w_target_nxt = r_target;
        w_cur_nxt    = r_cur_period;

        if (w_load) begin
            w_target_nxt = w_clamped;
        end

        // In IDLE a load takes effect immediately, including when the run
        // starts on the same edge. While running, the active period only
        // changes at the period boundary so the edge spacing stays exact.
        if (w_load && (r_state == ST_IDLE)) begin
            w_cur_nxt = w_clamped;
        end else if (w_last_low) begin
            w_cur_nxt = w_ramped;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers. Asynchronous reset pulls speed_out low
    // immediately, abandoning any period in progress.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_period  <= DEF_P;
            r_target      <= DEF_P;
            r_speed_out   <= 1'b0;
            r_rise_strobe <= 1'b0;
        end else begin
            r_cur_period  <= w_cur_nxt;
            r_target      <= w_target_nxt;
            r_speed_out   <= (w_state_nxt == ST_HIGH);
            r_rise_strobe <= w_start;
        end
    end

    // Rising-edge counter, free-running with natural 16-bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_cnt <= 16'd0;
        end else if (w_start) begin
            r_edge_cnt <= r_edge_cnt + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_period_ready = w_ready;
    assign o_speed_out    = r_speed_out;
    assign o_rise_strobe  = r_rise_strobe;
    assign o_cur_period   = r_cur_period;
    assign o_edge_cnt     = r_edge_cnt;

endmodule

// File: tb/tb_speed_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_speed_pulse_gen
//
// Directed bench for speed_pulse_gen. dut0 runs with RAMP_STEP=0 and dut1 with
// RAMP_STEP=150. Inputs are driven and outputs sampled on the falling clock
// edge; m_* select which instance the period-measuring tasks observe.
// -----------------------------------------------------------------------------
module tb_speed_pulse_gen;

    localparam int CNT_W = 26;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             en0, pload0, ready0, spd0, rise0;
    logic [CNT_W-1:0] pin0, cur0;
    logic [15:0]      ecnt0;
    logic             en1, pload1, ready1, spd1, rise1;
    logic [CNT_W-1:0] pin1, cur1;
    logic [15:0]      ecnt1;

    speed_pulse_gen #(
        .CNT_W(CNT_W), .MIN_PERIOD(16), .DEFAULT_PERIOD(100), .RAMP_STEP(0)
    ) dut0 (
        .clk(clk), .rst(rst), .i_en(en0), .i_period_in(pin0),
        .i_period_load(pload0), .o_period_ready(ready0), .o_speed_out(spd0),
        .o_rise_strobe(rise0), .o_cur_period(cur0), .o_edge_cnt(ecnt0)
    );

    speed_pulse_gen #(
        .CNT_W(CNT_W), .MIN_PERIOD(16), .DEFAULT_PERIOD(100), .RAMP_STEP(150)
    ) dut1 (
        .clk(clk), .rst(rst), .i_en(en1), .i_period_in(pin1),
        .i_period_load(pload1), .o_period_ready(ready1), .o_speed_out(spd1),
        .o_rise_strobe(rise1), .o_cur_period(cur1), .o_edge_cnt(ecnt1)
    );

    bit               sel;
    logic             m_spd, m_rise;
    logic [CNT_W-1:0] m_cur;
    logic [15:0]      m_ecnt;
    assign m_spd  = sel ? spd1  : spd0;
    assign m_rise = sel ? rise1 : rise0;
    assign m_cur  = sel ? cur1  : cur0;
    assign m_ecnt = sel ? ecnt1 : ecnt0;

    int n_total = 0;
    int n_bad   = 0;

    // Step falling edges until a rise strobe is seen, at most 'limit' edges.
    task automatic wait_rise(input int limit, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            if (m_rise === 1'b1) ok = 1'b1;
        end
    endtask

    // Called on the falling edge where a rise strobe is visible; returns the
    // high/low lengths of that period and stops on the next rising edge.
    // Any load request pending at entry is withdrawn after one cycle.
    task automatic measure(input int limit, output int hi, output int lo,
                           output int ns, output logic [15:0] ec,
                           output logic [CNT_W-1:0] cp, output bit ok);
        bit first;
        first = 1'b1;
        hi = 0; lo = 0; ns = 0;
        ec = m_ecnt;
        cp = m_cur;
        while (m_spd === 1'b1 && hi < limit) begin
            hi++;
            if (m_rise === 1'b1) ns++;
            @(negedge clk);
            if (first) begin pload0 = 1'b0; pload1 = 1'b0; first = 1'b0; end
        end
        while (m_spd === 1'b0 && lo < limit) begin
            lo++;
            if (m_rise === 1'b1) ns++;
            @(negedge clk);
            if (first) begin pload0 = 1'b0; pload1 = 1'b0; first = 1'b0; end
        end
        ok = (hi < limit) && (lo < limit);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        int highs, rises;
        rst = 1'b1;
        en0 = 1'b0; pload0 = 1'b0; pin0 = '0;
        en1 = 1'b0; pload1 = 1'b0; pin1 = '0;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        highs = 0; rises = 0;
        repeat (200) begin
            @(negedge clk);
            if (spd0 !== 1'b0) highs++;
            if (rise0 !== 1'b0) rises++;
        end
        n_total++; if (highs !== 0)   begin n_bad++; $display("FAIL reset_speed_low: got %0d high cycles, expected 0", highs); end
        n_total++; if (rises !== 0)   begin n_bad++; $display("FAIL reset_no_strobe: got %0d strobes, expected 0", rises); end
        n_total++; if (ecnt0 !== 16'd0) begin n_bad++; $display("FAIL reset_edge_cnt: got %0d, expected 0", ecnt0); end
        n_total++; if (cur0 !== 26'd100) begin n_bad++; $display("FAIL reset_cur_period: got %0d, expected 100", cur0); end
        n_total++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b, expected 1", ready0); end
        n_total++; if (cur1 !== 26'd100) begin n_bad++; $display("FAIL reset_cur_period_dut1: got %0d, expected 100", cur1); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_period_1000();
        int hi, lo, ns;
        logic [15:0] ec;
        logic [CNT_W-1:0] cp;
        bit ok;
        sel = 1'b0;
        pin0 = 26'd1000; pload0 = 1'b1;
        @(negedge clk);
        pload0 = 1'b0;
        n_total++; if (cur0 !== 26'd1000) begin n_bad++; $display("FAIL idle_load_cur: got %0d, expected 1000", cur0); end
        n_total++; if (ready0 !== 1'b1)   begin n_bad++; $display("FAIL idle_load_ready: got %0b, expected 1", ready0); end
        n_total++; if (spd0 !== 1'b0)     begin n_bad++; $display("FAIL idle_hold_low: got %0b, expected 0", spd0); end
        en0 = 1'b1;
        wait_rise(1, ok);
        n_total++; if (ok !== 1'b1) begin n_bad++; $display("FAIL start_next_cycle: got %0b, expected 1", ok); end
        for (int k = 0; k < 3; k++) begin
            measure(2000, hi, lo, ns, ec, cp, ok);
            n_total++; if (ok !== 1'b1)          begin n_bad++; $display("FAIL p1000_timeout[%0d]: got %0b, expected 1", k, ok); end
            n_total++; if (cp !== 26'd1000)       begin n_bad++; $display("FAIL p1000_cur[%0d]: got %0d, expected 1000", k, cp); end
            n_total++; if (hi !== 500)            begin n_bad++; $display("FAIL p1000_high[%0d]: got %0d, expected 500", k, hi); end
            n_total++; if (lo !== 500)            begin n_bad++; $display("FAIL p1000_low[%0d]: got %0d, expected 500", k, lo); end
            n_total++; if (ns !== 1)              begin n_bad++; $display("FAIL p1000_strobes[%0d]: got %0d, expected 1", k, ns); end
            n_total++; if (ec !== 16'(k + 1))     begin n_bad++; $display("FAIL p1000_edge_cnt[%0d]: got %0d, expected %0d", k, ec, k + 1); end
        end
    endtask

    // -------------------------------------------------------------------------
    // Loads of 101 and 5 while running: each takes effect one period later.
    task automatic test_odd_and_clamp();
        int exp_cp [4] = '{1000, 101, 101, 16};
        int exp_hi [4] = '{500, 50, 50, 8};
        int exp_lo [4] = '{500, 51, 51, 8};
        int hi, lo, ns;
        logic [15:0] ec;
        logic [CNT_W-1:0] cp;
        bit ok;
        sel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 0 || k == 2) begin
                n_total++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL run_load_ready[%0d]: got %0b, expected 1", k, ready0); end
                pin0   = (k == 0) ? 26'd101 : 26'd5;
                pload0 = 1'b1;
            end
            measure(2000, hi, lo, ns, ec, cp, ok);
            n_total++; if (ok !== 1'b1)               begin n_bad++; $display("FAIL odd_timeout[%0d]: got %0b, expected 1", k, ok); end
            n_total++; if (cp !== 26'(exp_cp[k]))     begin n_bad++; $display("FAIL odd_cur[%0d]: got %0d, expected %0d", k, cp, exp_cp[k]); end
            n_total++; if (hi !== exp_hi[k])          begin n_bad++; $display("FAIL odd_high[%0d]: got %0d, expected %0d", k, hi, exp_hi[k]); end
            n_total++; if (lo !== exp_lo[k])          begin n_bad++; $display("FAIL odd_low[%0d]: got %0d, expected %0d", k, lo, exp_lo[k]); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_en_drop();
        int hi, lo, ns, highs, rises;
        logic [15:0] ec, ec0;
        logic [CNT_W-1:0] cp;
        bit ok;
        sel = 1'b0;
        pin0 = 26'd1000; pload0 = 1'b1;
        measure(2000, hi, lo, ns, ec, cp, ok);
        n_total++; if (cp !== 26'd16) begin n_bad++; $display("FAIL drop_prev_cur: got %0d, expected 16", cp); end
        // Now on the first HIGH cycle of a 1000-cycle period.
        ec0 = ecnt0;
        hi  = 0;
        while (spd0 === 1'b1 && hi < 2000) begin
            hi++;
            if (hi == 10) en0 = 1'b0;
            @(negedge clk);
        end
        n_total++; if (hi !== 500) begin n_bad++; $display("FAIL drop_high_len: got %0d, expected 500", hi); end
        highs = 0; rises = 0;
        repeat (2000) begin
            if (spd0 !== 1'b0)  highs++;
            if (rise0 !== 1'b0) rises++;
            @(negedge clk);
        end
        n_total++; if (highs !== 0)   begin n_bad++; $display("FAIL drop_stays_low: got %0d high cycles, expected 0", highs); end
        n_total++; if (rises !== 0)   begin n_bad++; $display("FAIL drop_no_edges: got %0d strobes, expected 0", rises); end
        n_total++; if (ecnt0 !== ec0) begin n_bad++; $display("FAIL drop_edge_cnt: got %0d, expected %0d", ecnt0, ec0); end
        en0 = 1'b1;
        @(negedge clk);
        n_total++; if (rise0 !== 1'b1 || spd0 !== 1'b1) begin n_bad++; $display("FAIL reraise_next_cycle: got rise=%0b speed=%0b, expected 1 1", rise0, spd0); end
        n_total++; if (ecnt0 !== ec0 + 16'd1) begin n_bad++; $display("FAIL reraise_edge_cnt: got %0d, expected %0d", ecnt0, ec0 + 16'd1); end
        measure(2000, hi, lo, ns, ec, cp, ok);
        n_total++; if (hi !== 500 || lo !== 500) begin n_bad++; $display("FAIL reraise_period: got %0d/%0d, expected 500/500", hi, lo); end
    endtask

    // -------------------------------------------------------------------------
    // The edge counter is preloaded near its top so the wrap is reached in a
    // handful of MIN_PERIOD periods instead of 65536.
    task automatic test_wrap();
        logic [15:0] exp_ec [5] = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        int hi, lo, ns;
        logic [15:0] ec;
        logic [CNT_W-1:0] cp;
        bit ok;
        sel = 1'b0;
        pin0 = 26'd5; pload0 = 1'b1;
        measure(2000, hi, lo, ns, ec, cp, ok);
        force dut0.r_edge_cnt = 16'hFFFC;
        @(negedge clk);
        release dut0.r_edge_cnt;
        wait_rise(40, ok);
        n_total++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wrap_rise_timeout: got %0b, expected 1", ok); end
        for (int k = 0; k < 5; k++) begin
            measure(100, hi, lo, ns, ec, cp, ok);
            n_total++; if (ec !== exp_ec[k])        begin n_bad++; $display("FAIL wrap_edge_cnt[%0d]: got %0d, expected %0d", k, ec, exp_ec[k]); end
            n_total++; if (hi !== 8 || lo !== 8)    begin n_bad++; $display("FAIL wrap_spacing[%0d]: got %0d/%0d, expected 8/8", k, hi, lo); end
            n_total++; if (ns !== 1)                begin n_bad++; $display("FAIL wrap_strobes[%0d]: got %0d, expected 1", k, ns); end
        end
        en0 = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // RAMP_STEP=150: 1000 -> 1400 slews through 1150 and 1300; a load of 500
    // during the ramp must be ignored.
    task automatic test_ramp();
        int exp_cp [5] = '{1000, 1150, 1300, 1400, 1400};
        bit exp_rdy[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int hi, lo, ns;
        logic [15:0] ec;
        logic [CNT_W-1:0] cp;
        bit ok;
        sel = 1'b1;
        pin1 = 26'd1000; pload1 = 1'b1;
        @(negedge clk);
        pload1 = 1'b0;
        n_total++; if (cur1 !== 26'd1000) begin n_bad++; $display("FAIL ramp_idle_load: got %0d, expected 1000", cur1); end
        en1 = 1'b1;
        wait_rise(1, ok);
        n_total++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ramp_start: got %0b, expected 1", ok); end
        for (int k = 0; k < 5; k++) begin
            n_total++; if (ready1 !== exp_rdy[k]) begin n_bad++; $display("FAIL ramp_ready[%0d]: got %0b, expected %0b", k, ready1, exp_rdy[k]); end
            if (k == 0) begin pin1 = 26'd1400; pload1 = 1'b1; end
            if (k == 1) begin pin1 = 26'd500;  pload1 = 1'b1; end
            measure(3000, hi, lo, ns, ec, cp, ok);
            n_total++; if (ok !== 1'b1)                  begin n_bad++; $display("FAIL ramp_timeout[%0d]: got %0b, expected 1", k, ok); end
            n_total++; if (cp !== 26'(exp_cp[k]))        begin n_bad++; $display("FAIL ramp_cur[%0d]: got %0d, expected %0d", k, cp, exp_cp[k]); end
            n_total++; if (hi + lo !== exp_cp[k])        begin n_bad++; $display("FAIL ramp_spacing[%0d]: got %0d, expected %0d", k, hi + lo, exp_cp[k]); end
            n_total++; if (hi !== exp_cp[k] / 2)         begin n_bad++; $display("FAIL ramp_high[%0d]: got %0d, expected %0d", k, hi, exp_cp[k] / 2); end
            n_total++; if (ec !== 16'(k + 1))            begin n_bad++; $display("FAIL ramp_edge_cnt[%0d]: got %0d, expected %0d", k, ec, k + 1); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_high();
        sel = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (spd1 !== 1'b1) begin n_bad++; $display("FAIL pre_reset_high: got %0b, expected 1", spd1); end
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (spd1 !== 1'b0)     begin n_bad++; $display("FAIL async_reset_speed: got %0b, expected 0", spd1); end
        n_total++; if (ecnt1 !== 16'd0)   begin n_bad++; $display("FAIL async_reset_edge_cnt: got %0d, expected 0", ecnt1); end
        n_total++; if (cur1 !== 26'd100)  begin n_bad++; $display("FAIL async_reset_cur: got %0d, expected 100", cur1); end
        n_total++; if (ready1 !== 1'b1)   begin n_bad++; $display("FAIL async_reset_ready: got %0b, expected 1", ready1); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_period_1000();
        test_odd_and_clamp();
        test_en_drop();
        test_wrap();
        test_ramp();
        test_reset_mid_high();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
